// File: rtl/sysreg_pkg.sv
// sysreg_pkg
// Shared types and constants for the system-register write controller.
//   SYSREG_SEL_MODULE : sel_module encoding of sysreg instructions
//   sysreg_state_t    : controller state (IDLE / PEND)
//   sysreg_pend_t     : pending-entry layout at the default geometry
// The top module declares a parametrised twin of sysreg_pend_t so that
// non-default IDX_W/DATA_W keep exact widths.
package sysreg_pkg;

  localparam logic [2:0] SYSREG_SEL_MODULE = 3'b101;

  localparam int SYSREG_NUM_DEF    = 8;
  localparam int SYSREG_IDX_W_DEF  = 3;
  localparam int SYSREG_DATA_W_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } sysreg_state_t;

  typedef struct packed {
    logic [SYSREG_IDX_W_DEF-1:0]  num;
    logic [SYSREG_DATA_W_DEF-1:0] data;
  } sysreg_pend_t;

endpackage

// File: rtl/sysreg_wr_ctrl_onehot_dec.sv
// sysreg_onehot_dec
// Index to one-hot decoder for the system-register write enables.
// Ports:
//   i_en     : decode enable; vector is zero when low
//   i_idx    : register index
//   o_onehot : one-hot enable, zero when i_idx >= NUM_SYSREG
// Purely combinational.
module sysreg_onehot_dec
  import sysreg_pkg::*;
#(
  parameter int NUM_SYSREG = SYSREG_NUM_DEF,
  parameter int IDX_W      = SYSREG_IDX_W_DEF
) (
  input  logic                  i_en,
  input  logic [IDX_W-1:0]      i_idx,
  output logic [NUM_SYSREG-1:0] o_onehot
);

  // Only indices below NUM_SYSREG have a bit, so out-of-range indices
  // decode to all-zero instead of wrapping onto a real register.
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_SYSREG; i++) begin
      o_onehot[i] = i_en && (i_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/sysreg_wr_ctrl.sv
// sysreg_wr_ctrl
// Registered system-register write-enable generator. Merges control-packet
// writes and sysreg-instruction writes into one registered one-hot enable
// plus data, with packet priority and a one-entry pending buffer.
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   pkt_wen_i/num_i/data_i : control-packet write request
//   ins_wen_i/num_i/data_i : sysreg-instruction write request
//   stall_o                : pending buffer full, upstream holds its instr
//   sysreg_wen_vctr_o      : one-hot write enable (registered)
//   sysreg_wdata_o         : write data aligned with the enable
//   sysreg_w_terminate_o   : pulse aligned with a control-packet write
//   err_o                  : sticky out-of-range flag (SYSREG_WR_ERR_EN only)
// Build option: define SYSREG_WR_ERR_EN to add err_o.
//
// state | meaning
// IDLE  | pending buffer empty
// PEND  | pending buffer holds a deferred instruction write
module sysreg_wr_ctrl
  import sysreg_pkg::*;
#(
  parameter int NUM_SYSREG = SYSREG_NUM_DEF,
  parameter int IDX_W      = SYSREG_IDX_W_DEF,
  parameter int DATA_W     = SYSREG_DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pkt_wen_i,
  input  logic [IDX_W-1:0]      pkt_num_i,
  input  logic [DATA_W-1:0]     pkt_data_i,
  input  logic                  ins_wen_i,
  input  logic [IDX_W-1:0]      ins_num_i,
  input  logic [DATA_W-1:0]     ins_data_i,
  output logic                  stall_o,
  output logic [NUM_SYSREG-1:0] sysreg_wen_vctr_o,
  output logic [DATA_W-1:0]     sysreg_wdata_o,
  output logic                  sysreg_w_terminate_o
`ifdef SYSREG_WR_ERR_EN
  ,
  output logic                  err_o
`endif
);

  typedef struct packed {
    logic [IDX_W-1:0]  num;
    logic [DATA_W-1:0] data;
  } pend_t;

  sysreg_state_t r_state;
  pend_t         r_pend;
  logic          r_stall;
  logic [NUM_SYSREG-1:0] r_wen_vctr;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_term;

  logic              w_iss_en;
  logic [IDX_W-1:0]  w_iss_num;
  logic [DATA_W-1:0] w_iss_data;
  logic              w_iss_term;
  logic              w_capture;
  sysreg_state_t     w_next_state;
  logic              w_oor;
  logic [NUM_SYSREG-1:0] w_dec_vctr;

  // Issue mux: packets always win; a deferred instruction goes out on the
  // first packet-free cycle.
  always_comb begin
    w_iss_en     = 1'b0;
    w_iss_num    = '0;
    w_iss_data   = '0;
    w_iss_term   = 1'b0;
    w_capture    = 1'b0;
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (pkt_wen_i) begin
          w_iss_en   = 1'b1;
          w_iss_num  = pkt_num_i;
          w_iss_data = pkt_data_i;
          w_iss_term = 1'b1;
          if (ins_wen_i) begin
            w_capture    = 1'b1;
            w_next_state = PEND;
          end
        end else if (ins_wen_i) begin
          w_iss_en   = 1'b1;
          w_iss_num  = ins_num_i;
          w_iss_data = ins_data_i;
        end
      end
      PEND: begin
        w_iss_en = 1'b1;
        if (pkt_wen_i) begin
          w_iss_num  = pkt_num_i;
          w_iss_data = pkt_data_i;
          w_iss_term = 1'b1;
        end else begin
          w_iss_num    = r_pend.num;
          w_iss_data   = r_pend.data;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_oor = w_iss_en && (int'(w_iss_num) >= NUM_SYSREG);

  sysreg_onehot_dec #(
    .NUM_SYSREG (NUM_SYSREG),
    .IDX_W      (IDX_W)
  ) u_dec (
    .i_en     (w_iss_en),
    .i_idx    (w_iss_num),
    .o_onehot (w_dec_vctr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_stall    <= 1'b0;
      r_wen_vctr <= '0;
      r_wdata    <= '0;
      r_term     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_stall    <= (w_next_state == PEND);
      r_wen_vctr <= w_dec_vctr;
      // Dropped writes carry no data so the output bus stays quiet.
      r_wdata    <= w_oor ? '0 : w_iss_data;
      r_term     <= w_iss_term;
      if (w_capture) begin
        r_pend.num  <= ins_num_i;
        r_pend.data <= ins_data_i;
      end
    end
  end

  assign stall_o              = r_stall;
  assign sysreg_wen_vctr_o    = r_wen_vctr;
  assign sysreg_wdata_o       = r_wdata;
  assign sysreg_w_terminate_o = r_term;

`ifdef SYSREG_WR_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_oor) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_sysreg_wr_ctrl.sv
module tb_sysreg_wr_ctrl;

  localparam int NUM    = 6;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              pkt_wen_i;
  logic [IDX_W-1:0]  pkt_num_i;
  logic [DATA_W-1:0] pkt_data_i;
  logic              ins_wen_i;
  logic [IDX_W-1:0]  ins_num_i;
  logic [DATA_W-1:0] ins_data_i;
  logic              stall_o;
  logic [NUM-1:0]    sysreg_wen_vctr_o;
  logic [DATA_W-1:0] sysreg_wdata_o;
  logic              sysreg_w_terminate_o;
`ifdef SYSREG_WR_ERR_EN
  logic              err_o;
`endif

  sysreg_wr_ctrl #(
    .NUM_SYSREG (NUM),
    .IDX_W      (IDX_W),
    .DATA_W     (DATA_W)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pkt_wen_i            (pkt_wen_i),
    .pkt_num_i            (pkt_num_i),
    .pkt_data_i           (pkt_data_i),
    .ins_wen_i            (ins_wen_i),
    .ins_num_i            (ins_num_i),
    .ins_data_i           (ins_data_i),
    .stall_o              (stall_o),
    .sysreg_wen_vctr_o    (sysreg_wen_vctr_o),
    .sysreg_wdata_o       (sysreg_wdata_o),
    .sysreg_w_terminate_o (sysreg_w_terminate_o)
`ifdef SYSREG_WR_ERR_EN
    ,
    .err_o                (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned vctr;
    int unsigned wdata;
    bit          term;
    bit          stall;
    bit          err;
  } exp_t;

  typedef struct {
    int unsigned num;
    int unsigned data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  pend_q[$];
  bit   m_err;
  int   total;
  int   bad;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: a write that reaches a register index below NUM sets exactly
  // that bit; anything else is dropped and raises the sticky error.
  function automatic exp_t issue(input wr_t w, input bit term);
    exp_t e;
    e.term = term;
    e.stall = 1'b0;
    if (w.num < NUM) begin
      e.vctr  = 32'd1 << w.num;
      e.wdata = w.data;
    end else begin
      e.vctr  = 0;
      e.wdata = 0;
      m_err   = 1'b1;
    end
    e.err = 1'b0;
    return e;
  endfunction

  task automatic cycle(input bit p, input int unsigned pn, input int unsigned pd,
                       input bit i, input int unsigned inum, input int unsigned idat);
    exp_t e;
    wr_t  wp, wi;
    bit   deferred;
    @(negedge clk);
    pkt_wen_i  = p;
    pkt_num_i  = IDX_W'(pn);
    pkt_data_i = pd;
    ins_wen_i  = i;
    ins_num_i  = IDX_W'(inum);
    ins_data_i = idat;
    wp.num = pn;   wp.data = pd;
    wi.num = inum; wi.data = idat;
    deferred = (pend_q.size() != 0);
    e.vctr = 0; e.wdata = 0; e.term = 0; e.stall = 0; e.err = 0;
    if (p) begin
      e = issue(wp, 1'b1);
      if (i && !deferred) pend_q.push_back(wi);
    end else if (deferred) begin
      e = issue(pend_q.pop_front(), 1'b0);
    end else if (i) begin
      e = issue(wi, 1'b0);
    end
    e.stall = (pend_q.size() != 0);
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_vctr"}, sysreg_wen_vctr_o, 0);
    chk({tag, "_wdata"}, sysreg_wdata_o, 0);
    chk({tag, "_term"}, sysreg_w_terminate_o, 0);
    chk({tag, "_stall"}, stall_o, 0);
`ifdef SYSREG_WR_ERR_EN
    chk({tag, "_err"}, err_o, 0);
`endif
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic mid_cycle_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    pend_q.delete();
    m_err = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    pkt_wen_i = 1'b0;
    ins_wen_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one registered output word per cycle, compared against the
  // oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("vctr", sysreg_wen_vctr_o, e.vctr);
        chk("wdata", sysreg_wdata_o, e.wdata);
        chk("term", sysreg_w_terminate_o, e.term);
        chk("stall", stall_o, e.stall);
`ifdef SYSREG_WR_ERR_EN
        chk("err", err_o, e.err);
`endif
      end
    end
  end

  initial begin
    int waited;
    total = 0;
    bad   = 0;
    m_err = 1'b0;
    rst_n = 1'b0;
    pkt_wen_i = 0; pkt_num_i = 0; pkt_data_i = 0;
    ins_wen_i = 0; ins_num_i = 0; ins_data_i = 0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Single packet, then quiet.
    cycle(1, 3, 32'hA5A5, 0, 0, 0);
    idle_cycles(2);

    // Collision: packet first, instruction deferred.
    cycle(1, 1, 32'h11, 1, 5, 32'h55);
    idle_cycles(3);

    // Packets keep the deferred write waiting; new ins requests ignored.
    cycle(1, 2, 32'h22, 1, 4, 32'h44);
    cycle(1, 0, 32'h100, 1, 5, 32'h5);
    cycle(1, 2, 32'h102, 0, 0, 0);
    cycle(1, 4, 32'h104, 1, 5, 32'h5);
    cycle(0, 0, 0, 1, 5, 32'h5);
    cycle(0, 0, 0, 1, 5, 32'h5);
    idle_cycles(2);

    // Same index from both sources: instruction lands last.
    cycle(1, 2, 32'hAAAA, 1, 2, 32'hBBBB);
    idle_cycles(2);

    // Reset while a write is pending; it must never reappear.
    cycle(1, 1, 32'h1, 1, 3, 32'h33);
    cycle(1, 0, 32'h2, 0, 0, 0);
    mid_cycle_reset();
    idle_cycles(3);

    // Out-of-range indices from each source.
    cycle(0, 0, 0, 1, 7, 32'h77);
    idle_cycles(1);
    cycle(1, 6, 32'h66, 0, 0, 0);
    cycle(1, 7, 32'h67, 1, 6, 32'h76);
    idle_cycles(3);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 1) == 0, $urandom_range(0, 7), $urandom);
    end
    idle_cycles(2);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysreg_wr_ctrl.md
Name: sysreg_wr_ctrl

Overview:
- Parametrised, registered successor to the combinational system-register write-enable decoder in the Int0 execute stage.
- Merges two write sources into a single one-hot write-enable vector plus write data for the system-register file:
  - control-packet writes: memory write with generation MSB set
  - sysreg-instruction writes: sel_module = SYSREG with sel1 and sel2 set, pre-decoded upstream
- Adds fixed priority, a one-entry pending buffer with stall back-pressure, and a registered terminate pulse.

Parameters:
- NUM_SYSREG, 8: number of system registers (2..256).
- IDX_W, 3: index width; must satisfy 2**IDX_W >= NUM_SYSREG.
- DATA_W, 32: write-data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pkt_wen_i  in  1  control-packet write request (mem_wen & gen[msb])
- pkt_num_i  in  IDX_W  control-packet target index (gen low bits)
- pkt_data_i  in  DATA_W  control-packet write data
- ins_wen_i  in  1  sysreg-instruction write request
- ins_num_i  in  IDX_W  instruction target index (imm16 low bits)
- ins_data_i  in  DATA_W  instruction write data
- stall_o  out  1  pending buffer full; upstream must hold its instruction
- sysreg_wen_vctr_o  out  NUM_SYSREG  one-hot write enable, registered
- sysreg_wdata_o  out  DATA_W  write data aligned with sysreg_wen_vctr_o
- sysreg_w_terminate_o  out  1  one-cycle pulse, aligned with a control-packet write
- err_o  out  1  sticky out-of-range flag; present only with SYSREG_WR_ERR_EN

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, pending buffer empty, state IDLE. Reset mid-operation discards any pending write; nothing is replayed.
- Latency: a request accepted at edge t appears on the outputs for exactly one cycle after edge t. Outputs are zero in any cycle with no issue.
- sysreg_wen_vctr_o has at most one bit set.
- States: IDLE (pend empty) and PEND (pend full); stall_o = (state == PEND), registered.
- IDLE:
  - pkt only: issue pkt with terminate=1.
  - ins only: issue ins with terminate=0.
  - both: issue pkt with terminate=1, capture ins into pend, go to PEND.
  - neither: outputs zero.
- PEND:
  - ins_wen_i is ignored; upstream holds it while stall_o=1.
  - pkt_wen_i=1: issue pkt, pend retained, stay in PEND. Packets are never stalled.
  - pkt_wen_i=0: issue pend with terminate=0, go to IDLE. stall_o drops on the following cycle.
- Same index from both sources in one cycle: pkt write lands first, ins write lands on a later cycle. The instruction value is final.
- Back-to-back pkts in PEND can starve pend indefinitely; this is accepted by design, since the packet source is rate-limited by the memory port.
- Out-of-range index (>= NUM_SYSREG): the write is dropped (all-zero vector). For a pkt, terminate is still pulsed.
- Index to one-hot decode uses modular IDX_W arithmetic, with no wrap into valid registers.

Optional Feature:
- SYSREG_WR_ERR_EN
  - Defined: err_o port exists. Every dropped out-of-range write, from either source, sets err_o on the cycle after acceptance. err_o stays set until reset.
  - Undefined: no err_o port, and out-of-range writes are dropped silently. Logic is otherwise identical.

Decomposition:
- Package sysreg_pkg:
  - SYSREG_SEL_MODULE = 3'b101
  - state enum {IDLE, PEND}
  - default NUM_SYSREG/IDX_W/DATA_W constants
  - pending-entry struct {num, data}
- Sub-module sysreg_onehot_dec (parameters NUM_SYSREG, IDX_W): inputs en and idx; output one-hot vector, zero when idx is out of range. Purely combinational; instantiated once on the issue mux output.

Test Plan:
- Reset, then pkt_wen_i=1, pkt_num_i=3, pkt_data_i=0xA5A5 → next cycle: vctr=0x08, wdata=0xA5A5, terminate=1. Following cycle: all zero.
- Same cycle pkt num=1 data=0x11 and ins num=6 data=0x66 → cycle+1: vctr=0x02, terminate=1, stall_o=1. Cycle+2: vctr=0x40, wdata=0x66, terminate=0. Cycle+3: stall_o=0.
- In PEND, drive pkts on 3 consecutive cycles (num 0, 2, 4) → vctr 0x01, 0x04, 0x10 in order with stall_o held at 1. The pending ins issues on the first cycle without a pkt.
- In PEND, drive ins_wen_i=1 num=5 → ignored: no 0x20 pulse until re-presented after stall_o falls.
- Assert rst_n=0 mid-cycle while in PEND → outputs and stall_o go to 0 immediately, with no later issue of the pending write.
- NUM_SYSREG=6, ins num=7 → vctr all zero. With SYSREG_WR_ERR_EN, err_o=1 next cycle and stays set; without the macro, no error indication.
